piezo_arbiter: RTL and testbench

Arbitrates the single piezo `tone_generator` between three requesters: the continuous music stream, a fixed-length UI beep from a debounced pushbutton, and a short tick from rotary-wheel events. Sits between `music_streamer` / input conditioning and `tone_generator`. It drives the tone period and output enable, and asserts a pause handshake so the streamer holds its ROM address while preempted.

---
 rtl/piezo_arbiter.sv | 134 +++++++++++++
 tb/tb_piezo_arbiter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/piezo_arbiter.sv
// rtl/piezo_arbiter.sv - piezo speaker arbiter between music stream, UI beep and wheel click
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   stream_tone          streamer's requested tone period (0 = rest)
//   stream_enable        streamer allowed to sound
//   beep_req, click_req  single-cycle request pulses
//   tone                 registered tone period to the tone generator
//   output_enable        registered, high while any source owns the speaker
//   owner                registered, 0 idle / 1 stream / 2 beep / 3 click
//   stream_pause         registered, high while a beep or click owns the speaker

module piezo_arbiter #(
    parameter int                 tone_width   = 24,
    parameter int                 beep_cycles  = 3_300_000,
    parameter int                 click_cycles = 330_000,
    parameter logic [tone_width-1:0] beep_tone  = 24'd37500,
    parameter logic [tone_width-1:0] click_tone = 24'd8250
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [tone_width-1:0] stream_tone,
    input  logic                  stream_enable,
    input  logic                  beep_req,
    input  logic                  click_req,
    output logic [tone_width-1:0] tone,
    output logic                  output_enable,
    output logic [1:0]            owner,
    output logic                  stream_pause
);

    localparam int cnt_max = (beep_cycles > click_cycles) ? beep_cycles : click_cycles;
    localparam int cnt_w   = $clog2(cnt_max + 1);

    localparam logic [cnt_w-1:0] beep_load  = cnt_w'(beep_cycles);
    localparam logic [cnt_w-1:0] click_load = cnt_w'(click_cycles);

    typedef enum logic [1:0] {
        st_idle   = 2'd0,
        st_stream = 2'd1,
        st_beep   = 2'd2,
        st_click  = 2'd3
    } state_t;

    state_t                  state, state_nxt;
    logic [cnt_w-1:0]        remaining, remaining_nxt;
    logic                    click_pending, click_pending_nxt;
    logic [tone_width-1:0]   tone_nxt;
    logic                    stream_ok;

    assign stream_ok = stream_enable && (stream_tone != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= st_idle;
            remaining     <= '0;
            click_pending <= 1'b0;
            tone          <= '0;
            output_enable <= 1'b0;
            owner         <= 2'd0;
            stream_pause  <= 1'b0;
        end else begin
            state         <= state_nxt;
            remaining     <= remaining_nxt;
            click_pending <= click_pending_nxt;
            tone          <= tone_nxt;
            output_enable <= (state_nxt != st_idle);
            owner         <= state_nxt;
            stream_pause  <= (state_nxt == st_beep) || (state_nxt == st_click);
        end
    end

    always_comb begin
        state_nxt         = state;
        remaining_nxt     = remaining;
        click_pending_nxt = click_pending;

        if (beep_req) begin
            // Beep always wins; a simultaneous click is queued behind it.
            state_nxt     = st_beep;
            remaining_nxt = beep_load;
            if (click_req) begin
                click_pending_nxt = 1'b1;
            end
        end else begin
            case (state)
                st_idle, st_stream: begin
                    if (click_req) begin
                        state_nxt     = st_click;
                        remaining_nxt = click_load;
                    end else begin
                        state_nxt = stream_ok ? st_stream : st_idle;
                    end
                end
                st_click: begin
                    if (click_req) begin
                        remaining_nxt = click_load;
                    end else if (remaining <= cnt_w'(1)) begin
                        state_nxt     = stream_ok ? st_stream : st_idle;
                        remaining_nxt = '0;
                    end else begin
                        remaining_nxt = remaining - cnt_w'(1);
                    end
                end
                default: begin // st_beep
                    if (click_req) begin
                        click_pending_nxt = 1'b1;
                    end
                    if (remaining <= cnt_w'(1)) begin
                        // A click arriving on the beep's last cycle is still honoured.
                        if (click_pending || click_req) begin
                            state_nxt         = st_click;
                            remaining_nxt     = click_load;
                            click_pending_nxt = 1'b0;
                        end else begin
                            state_nxt     = stream_ok ? st_stream : st_idle;
                            remaining_nxt = '0;
                        end
                    end else begin
                        remaining_nxt = remaining - cnt_w'(1);
                    end
                end
            endcase
        end

        case (state_nxt)
            st_stream: tone_nxt = stream_tone;
            st_beep:   tone_nxt = beep_tone;
            st_click:  tone_nxt = click_tone;
            default:   tone_nxt = '0;
        endcase
    end

endmodule

// File: tb/tb_piezo_arbiter.sv
// tb/tb_piezo_arbiter.sv - directed self-checking bench for piezo_arbiter

module tb_piezo_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] stream_tone;
    logic        stream_enable;
    logic        beep_req;
    logic        click_req;
    logic [23:0] tone;
    logic        output_enable;
    logic [1:0]  owner;
    logic        stream_pause;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    piezo_arbiter #(
        .tone_width   (24),
        .beep_cycles  (8),
        .click_cycles (3),
        .beep_tone    (24'd100),
        .click_tone   (24'd50)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stream_tone   (stream_tone),
        .stream_enable (stream_enable),
        .beep_req      (beep_req),
        .click_req     (click_req),
        .tone          (tone),
        .output_enable (output_enable),
        .owner         (owner),
        .stream_pause  (stream_pause)
    );

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the current cycle shows the given owner/tone, then advance; n times.
    task automatic run(input string tag, input int own, input int tn, input int n);
        for (int i = 0; i < n; i++) begin
            check({tag, " owner"}, int'(owner), own);
            check({tag, " tone"}, int'(tone), tn);
            check({tag, " oe"}, int'(output_enable), (own != 0) ? 1 : 0);
            check({tag, " pause"}, int'(stream_pause), (own >= 2) ? 1 : 0);
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; stream_tone = '0; stream_enable = 1'b0;
        beep_req = 1'b0; click_req = 1'b0;

        // 1. reset and streaming
        tick();
        run("rst1", 0, 0, 1);
        run("rst2", 0, 0, 1);
        rst = 1'b0;
        stream_enable = 1'b1; stream_tone = 24'd500;
        tick();
        run("stream", 1, 500, 1);
        stream_tone = 24'd0;
        tick();
        run("rest", 0, 0, 1);

        // 2. beep preempts stream
        stream_tone = 24'd500;
        tick();
        beep_req = 1'b1; tick(); beep_req = 1'b0;
        run("beep", 2, 100, 8);
        run("resume", 1, 500, 1);

        // 3. clicks pended behind a beep coalesce into one
        stream_enable = 1'b0; stream_tone = '0;
        tick();
        beep_req = 1'b1; tick(); beep_req = 1'b0;
        run("pbeep", 2, 100, 3);
        click_req = 1'b1; run("pbeep", 2, 100, 1);
        click_req = 1'b0; run("pbeep", 2, 100, 1);
        click_req = 1'b1; run("pbeep", 2, 100, 1);
        click_req = 1'b0; run("pbeep", 2, 100, 2);
        run("pclick", 3, 50, 3);
        run("pidle", 0, 0, 2);

        // 4. simultaneous requests, then click retrigger
        beep_req = 1'b1; click_req = 1'b1; tick();
        beep_req = 1'b0; click_req = 1'b0;
        run("sbeep", 2, 100, 8);
        run("sclick", 3, 50, 1);
        click_req = 1'b1; run("sclick", 3, 50, 1);
        click_req = 1'b0; run("rclick", 3, 50, 3);
        run("sidle", 0, 0, 1);

        // 5. beep retrigger, then beep aborting a click
        beep_req = 1'b1; tick(); beep_req = 1'b0;
        run("rbeep", 2, 100, 4);
        beep_req = 1'b1; run("rbeep", 2, 100, 1);
        beep_req = 1'b0; run("rbeep2", 2, 100, 8);
        run("ridle", 0, 0, 1);
        click_req = 1'b1; tick(); click_req = 1'b0;
        run("aclick", 3, 50, 1);
        beep_req = 1'b1; run("aclick", 3, 50, 1);
        beep_req = 1'b0; run("abeep", 2, 100, 8);
        run("noreplay", 0, 0, 2);

        // 6. reset mid-beep with a click pending
        beep_req = 1'b1; tick(); beep_req = 1'b0;
        run("mbeep", 2, 100, 1);
        click_req = 1'b1; run("mbeep", 2, 100, 1);
        click_req = 1'b0; run("mbeep", 2, 100, 1);
        rst = 1'b1; run("mbeep", 2, 100, 1);
        run("mrst", 0, 0, 1);
        rst = 1'b0;
        tick();
        beep_req = 1'b1; tick(); beep_req = 1'b0;
        run("fbeep", 2, 100, 8);
        run("fidle", 0, 0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
